// File: rtl/ysyx_22040895_immgen.sv
// Decode-stage immediate generator: extracts and extends the RISC-V immediate,
// adds it to the PC, and queues {simm, target, fmt_err} in a DEPTH-entry FIFO.
module ysyx_22040895_immgen #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     inst_i,
  input  logic [2:0]      fmt_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] simm_o,
  output logic [XLEN-1:0] target_o,
  output logic            fmt_err_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("ysyx_22040895_immgen: XLEN must be 32 or 64");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ysyx_22040895_immgen: DEPTH must be a power of two >= 2");
  end

  typedef struct packed {
    logic [XLEN-1:0] simm;
    logic [XLEN-1:0] target;
    logic            fmt_err;
  } entry_t;

  logic [31:0]     imm32;
  logic            fmt_bad;
  logic [63:0]     imm64;
  logic [XLEN-1:0] simm_in;
  logic [XLEN-1:0] target_in;
  logic            unused_opcode;

  // Every format is first widened to a 32-bit value already extended, so the
  // final widening to XLEN is a plain sign-extension of bit 31 (0 for Z).
  always_comb begin
    imm32   = '0;
    fmt_bad = 1'b0;
    case (fmt_i)
      3'd0: imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      3'd1: imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      3'd2: imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                     inst_i[11:8], 1'b0};
      3'd3: imm32 = {inst_i[31:12], 12'b0};
      3'd4: imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                     inst_i[30:21], 1'b0};
      3'd5: imm32 = {27'b0, inst_i[19:15]};
      default: fmt_bad = 1'b1;
    endcase
  end

  assign unused_opcode = ^inst_i[6:0];
  assign imm64         = {{32{imm32[31]}}, imm32};
  assign simm_in       = imm64[XLEN-1:0];
  assign target_in     = pc_i + simm_in;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push;
  logic          pop;
  entry_t        head;

  assign in_ready_o  = (count_q != CW'(DEPTH));
  assign out_valid_o = (count_q != '0);
  assign push        = in_valid_i && in_ready_o && !flush_i;
  assign pop         = out_valid_o && out_ready_i && !flush_i;

  // Flush wins over any concurrent push or pop; storage contents are left as-is
  // because an empty count already hides them.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{simm: simm_in, target: target_in, fmt_err: fmt_bad};
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign simm_o    = out_valid_o ? head.simm    : '0;
  assign target_o  = out_valid_o ? head.target  : '0;
  assign fmt_err_o = out_valid_o ? head.fmt_err : 1'b0;

endmodule

// File: tb/tb_ysyx_22040895_immgen.sv
// Directed self-checking bench for ysyx_22040895_immgen (XLEN=64 main instance,
// XLEN=32 companion instance sharing the same stimulus).
module tb_ysyx_22040895_immgen;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] inst_i;
  logic [2:0]  fmt_i;
  logic [63:0] pc_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [63:0] simm_o;
  logic [63:0] target_o;
  logic        fmt_err_o;

  logic [31:0] pc32;
  logic        in_ready32;
  logic        out_valid32;
  logic [31:0] simm32;
  logic [31:0] target32;
  logic        fmt_err32;

  int checks;
  int errors;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [2:0]  fmt;
    logic [63:0] pc;
    logic [63:0] simm;
    logic [63:0] target;
    logic        err;
  } vec_t;

  vec_t vecs [10];

  assign pc32 = pc_i[31:0];

  ysyx_22040895_immgen #(.XLEN(64), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .inst_i     (inst_i),
    .fmt_i      (fmt_i),
    .pc_i       (pc_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .simm_o     (simm_o),
    .target_o   (target_o),
    .fmt_err_o  (fmt_err_o)
  );

  ysyx_22040895_immgen #(.XLEN(32), .DEPTH(2)) dut32 (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready32),
    .inst_i     (inst_i),
    .fmt_i      (fmt_i),
    .pc_i       (pc32),
    .out_valid_o(out_valid32),
    .out_ready_i(out_ready_i),
    .simm_o     (simm32),
    .target_o   (target32),
    .fmt_err_o  (fmt_err32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %0b exp 0", out_valid_o); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %0b exp 1", in_ready_o); end
    checks++; if (simm_o !== 64'h0) begin errors++; $display("[TB] FAIL reset_simm got %h exp 0", simm_o); end
    checks++; if (target_o !== 64'h0) begin errors++; $display("[TB] FAIL reset_target got %h exp 0", target_o); end
    checks++; if (fmt_err_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_fmt_err got %0b exp 0", fmt_err_o); end
    @(negedge clk);
    rst = 1'b1;
    step();
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_out_valid got %0b exp 0", out_valid_o); end
  endtask

  task automatic test_formats();
    vecs[0] = '{"I_neg",  32'hFFF00093, 3'd0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_7FFF_FFFF, 1'b0};
    vecs[1] = '{"S_neg",  32'hFE000C23, 3'd1, 64'h0000_0000_0000_1000, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0000_0000_0000_0FF8, 1'b0};
    vecs[2] = '{"B_neg",  32'hFE000EE3, 3'd2, 64'h0000_0000_8000_0010, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_8000_000C, 1'b0};
    vecs[3] = '{"U_neg",  32'h800000B7, 3'd3, 64'h0000_0000_0000_1000, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_1000, 1'b0};
    vecs[4] = '{"J_pos",  32'h0010006F, 3'd4, 64'h0000_0000_0000_1000, 64'h0000_0000_0000_0800, 64'h0000_0000_0000_1800, 1'b0};
    vecs[5] = '{"J_neg",  32'h8000006F, 3'd4, 64'h0000_0000_0020_0000, 64'hFFFF_FFFF_FFF0_0000, 64'h0000_0000_0010_0000, 1'b0};
    vecs[6] = '{"Z_csr",  32'h000FD073, 3'd5, 64'h0000_0000_0000_0100, 64'h0000_0000_0000_001F, 64'h0000_0000_0000_011F, 1'b0};
    vecs[7] = '{"Z_ones", 32'hFFFFFFFF, 3'd5, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_001F, 64'h0000_0000_0000_001F, 1'b0};
    vecs[8] = '{"fmt6",   32'hFFFFFFFF, 3'd6, 64'h0000_0000_0000_0200, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0200, 1'b1};
    vecs[9] = '{"fmt7",   32'h12345678, 3'd7, 64'h0000_0000_0000_0300, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0300, 1'b1};
    out_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid_i = 1'b1;
      inst_i     = vecs[i].inst;
      fmt_i      = vecs[i].fmt;
      pc_i       = vecs[i].pc;
      step();
      in_valid_i = 1'b0;
      checks++; if (out_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL %s out_valid got %0b exp 1", vecs[i].name, out_valid_o); end
      checks++; if (simm_o !== vecs[i].simm) begin errors++; $display("[TB] FAIL %s simm got %h exp %h", vecs[i].name, simm_o, vecs[i].simm); end
      checks++; if (target_o !== vecs[i].target) begin errors++; $display("[TB] FAIL %s target got %h exp %h", vecs[i].name, target_o, vecs[i].target); end
      checks++; if (fmt_err_o !== vecs[i].err) begin errors++; $display("[TB] FAIL %s fmt_err got %0b exp %0b", vecs[i].name, fmt_err_o, vecs[i].err); end
      checks++; if (out_valid32 !== 1'b1) begin errors++; $display("[TB] FAIL %s out_valid32 got %0b exp 1", vecs[i].name, out_valid32); end
      checks++; if (simm32 !== vecs[i].simm[31:0]) begin errors++; $display("[TB] FAIL %s simm32 got %h exp %h", vecs[i].name, simm32, vecs[i].simm[31:0]); end
      checks++; if (target32 !== vecs[i].target[31:0]) begin errors++; $display("[TB] FAIL %s target32 got %h exp %h", vecs[i].name, target32, vecs[i].target[31:0]); end
      checks++; if (fmt_err32 !== vecs[i].err) begin errors++; $display("[TB] FAIL %s fmt_err32 got %0b exp %0b", vecs[i].name, fmt_err32, vecs[i].err); end
      step();
      checks++; if (out_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL %s drained got %0b exp 0", vecs[i].name, out_valid_o); end
    end
  endtask

  task automatic test_backpressure();
    out_ready_i = 1'b0;
    fmt_i       = 3'd0;
    pc_i        = 64'h0;
    in_valid_i  = 1'b1;
    inst_i      = 32'h00100093;
    step();
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_one got %0b exp 1", in_ready_o); end
    inst_i = 32'h00200093;
    step();
    checks++; if (in_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_full got %0b exp 0", in_ready_o); end
    inst_i = 32'h00300093;
    step();
    checks++; if (simm_o !== 64'd1) begin errors++; $display("[TB] FAIL bp_hold_A got %h exp 1", simm_o); end
    checks++; if (in_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL bp_still_full got %0b exp 0", in_ready_o); end
    out_ready_i = 1'b1;
    step();
    checks++; if (simm_o !== 64'd2) begin errors++; $display("[TB] FAIL bp_head_B got %h exp 2", simm_o); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_back got %0b exp 1", in_ready_o); end
    step();
    in_valid_i = 1'b0;
    checks++; if (out_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid_C got %0b exp 1", out_valid_o); end
    checks++; if (simm_o !== 64'd3) begin errors++; $display("[TB] FAIL bp_head_C got %h exp 3", simm_o); end
    checks++; if (target_o !== 64'd3) begin errors++; $display("[TB] FAIL bp_target_C got %h exp 3", target_o); end
    step();
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL bp_empty got %0b exp 0", out_valid_o); end
  endtask

  task automatic test_back_to_back();
    out_ready_i = 1'b1;
    fmt_i       = 3'd0;
    in_valid_i  = 1'b1;
    inst_i      = {12'(16), 20'h00093};
    pc_i        = 64'h0;
    step();
    for (int i = 1; i <= 8; i++) begin
      inst_i = {12'(16 + i), 20'h00093};
      pc_i   = 64'(i * 4096);
      step();
      checks++; if (simm_o !== 64'(16 + i)) begin errors++; $display("[TB] FAIL b2b_simm_%0d got %h exp %h", i, simm_o, 64'(16 + i)); end
      checks++; if (target_o !== 64'(i * 4096 + 16 + i)) begin errors++; $display("[TB] FAIL b2b_target_%0d got %h exp %h", i, target_o, 64'(i * 4096 + 16 + i)); end
      checks++; if (in_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_%0d got %0b exp 1", i, in_ready_o); end
    end
    in_valid_i = 1'b0;
    step();
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain got %0b exp 0", out_valid_o); end
  endtask

  task automatic test_flush();
    out_ready_i = 1'b0;
    fmt_i       = 3'd0;
    pc_i        = 64'h0;
    in_valid_i  = 1'b1;
    inst_i      = 32'h00100093;
    step();
    inst_i = 32'h00200093;
    step();
    inst_i  = 32'h00300093;
    flush_i = 1'b1;
    step();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_full_valid got %0b exp 0", out_valid_o); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL flush_full_ready got %0b exp 1", in_ready_o); end
    step();
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_full_no_C got %0b exp 0", out_valid_o); end
    in_valid_i = 1'b1;
    inst_i     = 32'h00400093;
    step();
    inst_i      = 32'h00500093;
    out_ready_i = 1'b1;
    flush_i     = 1'b1;
    step();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_push_valid got %0b exp 0", out_valid_o); end
    step();
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_push_dropped got %0b exp 0", out_valid_o); end
    in_valid_i = 1'b1;
    inst_i     = 32'h00600093;
    step();
    in_valid_i = 1'b0;
    checks++; if (simm_o !== 64'd6) begin errors++; $display("[TB] FAIL flush_refill got %h exp 6", simm_o); end
    step();
  endtask

  task automatic test_async_reset();
    out_ready_i = 1'b0;
    fmt_i       = 3'd0;
    pc_i        = 64'h100;
    in_valid_i  = 1'b1;
    inst_i      = 32'h00700093;
    step();
    inst_i = 32'h00800093;
    step();
    in_valid_i = 1'b0;
    checks++; if (simm_o !== 64'd7) begin errors++; $display("[TB] FAIL ar_before got %h exp 7", simm_o); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL ar_valid got %0b exp 0", out_valid_o); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL ar_ready got %0b exp 1", in_ready_o); end
    checks++; if (simm_o !== 64'h0) begin errors++; $display("[TB] FAIL ar_simm got %h exp 0", simm_o); end
    checks++; if (target_o !== 64'h0) begin errors++; $display("[TB] FAIL ar_target got %h exp 0", target_o); end
    checks++; if (fmt_err_o !== 1'b0) begin errors++; $display("[TB] FAIL ar_fmt_err got %0b exp 0", fmt_err_o); end
    #2;
    rst = 1'b1;
    step();
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL ar_after_release got %0b exp 0", out_valid_o); end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b0;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    inst_i      = 32'h0;
    fmt_i       = 3'd0;
    pc_i        = 64'h0;
    $display("[TB] starting");
    test_reset();
    test_formats();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22040895_immgen.md
# ysyx_22040895_immgen

Parametrised, buffered immediate generator for the decode stage of the ysyx_22040895 core. It extracts the immediate from a 32-bit RISC-V instruction word for every base format (I/S/B/U/J) plus the CSR zero-extended uimm. It sign- or zero-extends the immediate to XLEN and also computes the PC-relative target pc + imm. Results are queued in a small FIFO with valid/ready handshakes on both sides, so decode and execute can stall independently.

## Interface
Parameters:
- XLEN, 64, datapath width; legal values 32 or 64; any other value is an elaboration error.
- DEPTH, 2, output FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low (asserted when 0).
- flush_i  in  1  synchronous pipeline flush; drops all buffered entries.
- in_valid_i  in  1  instruction present.
- in_ready_o  out  1  block can accept an instruction (FIFO not full).
- inst_i  in  32  instruction word.
- fmt_i  in  3  format: 0 I, 1 S, 2 B, 3 U, 4 J, 5 Z (CSR uimm), 6/7 illegal.
- pc_i  in  XLEN  PC of the instruction.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  consumer takes head entry.
- simm_o  out  XLEN  extended immediate of head entry.
- target_o  out  XLEN  pc + simm of head entry.
- fmt_err_o  out  1  head entry had an illegal fmt.

## Operation
- Immediate extraction, with S(x) meaning sign-extend from x's MSB to XLEN:
  - I: S(inst[31:20]).
  - S: S({inst[31:25], inst[11:7]}).
  - B: S({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - U: S({inst[31:12], 12'b0}); for XLEN=32 this is the raw value.
  - J: S({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - Z: zero-extend inst[19:15].
  - fmt 6/7: simm = 0, fmt_err = 1; the entry is still queued.
- target = pc_i + simm, modulo 2^XLEN (carry-out discarded); computed for every format.
- Extraction and add are combinational on input. The FIFO stores {simm, target, fmt_err} per entry.
- Push occurs when in_valid_i && in_ready_o && !flush_i. Pop occurs when out_valid_o && out_ready_i.
- in_ready_o = (count != DEPTH). There is no combinational in→out path and no pass-through when full, so in_ready_o does not depend on out_ready_i.
- Push and pop in the same cycle are allowed when 0 < count < DEPTH; count is unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits, range 0..DEPTH.
- flush_i: at the next edge count, read pointer and write pointer go to 0. A concurrent push and a concurrent pop are both discarded. Flush has priority over everything except reset.
- When out_valid_o = 0, simm_o, target_o and fmt_err_o are driven 0.

## Timing
- Reset (rst = 0, asynchronous) sets count = 0 and pointers = 0. Immediately: out_valid_o = 0, in_ready_o = 1, simm_o = target_o = 0, fmt_err_o = 0. The reset value of FIFO storage is don't-care.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge. Release is synchronous to the next rising edge.
- Latency: an instruction accepted at edge N is visible on out_valid_o and outputs after edge N (1 cycle), provided the FIFO was empty.
- Outputs come from the head entry only. They stay stable while out_valid_o = 1 and out_ready_i = 0.
- in_ready_o falls in the cycle after the push that fills the FIFO. It rises in the cycle after the first pop from full.
- Ordering is strict FIFO. Every accepted instruction produces exactly one output, unless flushed or reset.

## Test plan
- I-type, XLEN=64: inst 0xFFF00093, fmt 0, pc 0x0000_0000_8000_0000 -> next cycle out_valid=1, simm 0xFFFF_FFFF_FFFF_FFFF, target 0x0000_0000_7FFF_FFFF, fmt_err 0.
- B-type: inst 0xFE000EE3, fmt 2, pc 0x8000_0010 -> simm −4 (0xFFFF_FFFF_FFFF_FFFC), target 0x8000_000C.
- U-type and Z:
  - inst 0x800000B7, fmt 3 -> simm 0xFFFF_FFFF_8000_0000 (XLEN=64); with XLEN=32 -> 0x8000_0000.
  - inst 0x000FD073, fmt 5 -> simm 0x1F.
  - fmt 7 -> simm 0, fmt_err 1.
- Backpressure, DEPTH=2: out_ready_i=0, push A, B. in_ready_o = 0 after the second push, and a third instruction C is held by the source. Raise out_ready_i -> A, then B, then C popped in order. C is accepted the cycle after in_ready_o returns high.
- Simultaneous push/pop with count=1 for 8 cycles -> count stays 1, outputs track one cycle behind input, no drops.
- Flush and reset:
  - flush_i with 2 entries plus a concurrent push -> next cycle out_valid 0, in_ready 1, and the pushed item is never output.
  - rst pulled low mid-stream without a clock -> out_valid_o = 0 and outputs = 0 immediately.
